// File: rtl/net_router_output_pkt_arb.sv
// Output-port arbiter: round-robin among input queues with the grant held for a
// whole head-to-tail packet, gated by downstream ready or an internal credit count.
module net_router_output_pkt_arb #(
    parameter int unsigned p_num_reqs  = 3,
    parameter int unsigned p_sel_nbits = $clog2(p_num_reqs),
    parameter int unsigned p_credit_en = 0,
    parameter int unsigned p_credits   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [p_num_reqs-1:0]              reqs,
    input  logic [p_num_reqs-1:0]              tails,
    output logic [p_num_reqs-1:0]              grants,
    output logic                               out_val,
    input  logic                               out_rdy,
    input  logic                               credit_return,
    output logic [p_sel_nbits-1:0]             xbar_sel,
    output logic                               locked,
    output logic [$clog2(p_credits+1)-1:0]     credits
);

    localparam int unsigned LP_CW = $clog2(p_credits + 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [p_sel_nbits-1:0] r_owner;
    logic [p_sel_nbits-1:0] r_ptr;
    logic [p_sel_nbits-1:0] w_owner_nxt;
    logic [p_sel_nbits-1:0] w_ptr_nxt;
    logic [p_sel_nbits-1:0] w_winner;
    logic [p_sel_nbits-1:0] w_sel;
    logic                   w_any;
    logic                   w_can_send;
    logic                   w_xfer;
    logic [LP_CW-1:0]       r_credits;

    function automatic logic [p_sel_nbits-1:0] f_inc(input logic [p_sel_nbits-1:0] v);
        return (32'(v) == p_num_reqs - 1) ? '0 : v + p_sel_nbits'(1);
    endfunction

    // First requester at or above the priority pointer, wrapping modulo N.
    always_comb begin : p_search
        int unsigned v_idx;
        w_any    = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int unsigned i = 0; i < p_num_reqs; i++) begin
            v_idx = (32'(r_ptr) + i) % p_num_reqs;
            if (!w_any && reqs[v_idx]) begin
                w_any    = 1'b1;
                w_winner = p_sel_nbits'(v_idx);
            end
        end
    end

    assign w_can_send = (p_credit_en != 0) ? (r_credits != '0) : out_rdy;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_sel       = w_winner;
        w_xfer      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any && w_can_send) begin
                    w_xfer = 1'b1;
                    if (tails[w_winner]) begin
                        w_ptr_nxt = f_inc(w_winner);
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_winner;
                    end
                end
            end
            ST_LOCKED: begin
                w_sel = r_owner;
                if (reqs[r_owner] && w_can_send) begin
                    w_xfer = 1'b1;
                    if (tails[r_owner]) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = f_inc(r_owner);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Combinational outputs are forced quiet while reset is held.
    assign grants   = (reset && w_xfer) ? (p_num_reqs'(1) << w_sel) : '0;
    assign out_val  = |grants;
    assign xbar_sel = reset ? w_sel : '0;
    assign locked   = (r_state == ST_LOCKED);
    assign credits  = r_credits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Send and return in the same cycle cancel; a return at full count is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credits <= (p_credit_en != 0) ? LP_CW'(p_credits) : '0;
        end else if (p_credit_en != 0) begin
            if (w_xfer && !credit_return) begin
                r_credits <= r_credits - LP_CW'(1);
            end else if (!w_xfer && credit_return && (r_credits != LP_CW'(p_credits))) begin
                r_credits <= r_credits + LP_CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_net_router_output_pkt_arb.sv
// Bench: three arbiter configurations (N=3 ready-gated, N=3 two-credit, N=5 four-credit)
// checked every cycle against a queue-free behavioural model plus directed literal expectations.
module tb_net_router_output_pkt_arb;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rA, tA, gA;  logic rdyA, vA, lA;  logic [1:0] sA;  logic [2:0] cA;
    logic [2:0] rB, tB, gB;  logic crB, vB, lB;   logic [1:0] sB;  logic [1:0] cB;
    logic [4:0] rC, tC, gC;  logic crC, vC, lC;   logic [2:0] sC;  logic [2:0] cC;

    net_router_output_pkt_arb #(.p_num_reqs(3), .p_sel_nbits(2), .p_credit_en(0), .p_credits(4)) dA (
        .clk(clk), .reset(reset), .reqs(rA), .tails(tA), .grants(gA), .out_val(vA),
        .out_rdy(rdyA), .credit_return(1'b0), .xbar_sel(sA), .locked(lA), .credits(cA));
    net_router_output_pkt_arb #(.p_num_reqs(3), .p_sel_nbits(2), .p_credit_en(1), .p_credits(2)) dB (
        .clk(clk), .reset(reset), .reqs(rB), .tails(tB), .grants(gB), .out_val(vB),
        .out_rdy(1'b0), .credit_return(crB), .xbar_sel(sB), .locked(lB), .credits(cB));
    net_router_output_pkt_arb #(.p_num_reqs(5), .p_sel_nbits(3), .p_credit_en(1), .p_credits(4)) dC (
        .clk(clk), .reset(reset), .reqs(rC), .tails(tC), .grants(gC), .out_val(vC),
        .out_rdy(1'b0), .credit_return(crC), .xbar_sel(sC), .locked(lC), .credits(cC));

    typedef struct {
        int lk;
        int own;
        int ptr;
        int cr;
    } mst_t;
    mst_t st[3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: owner-or-round-robin pick, gated by ready or credits.
    task automatic model_cmp(input int k, input int n, input int ce, input int pc,
                             input logic [7:0] rq, input logic [7:0] tl,
                             input logic rdy, input logic cret,
                             input logic [7:0] ag, input logic av, input int asel,
                             input logic alk, input int acr, input string nm);
        logic [7:0] eg;
        int w;
        bit any, cs, xfer;
        eg = '0; w = 0; any = 0; xfer = 0;
        if (!reset) begin
            st[k] = '{lk: 0, own: 0, ptr: 0, cr: (ce != 0) ? pc : 0};
        end else begin
            cs = (ce != 0) ? (st[k].cr != 0) : rdy;
            if (st[k].lk != 0) begin
                w = st[k].own;
                any = rq[w];
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (!any && rq[(st[k].ptr + i) % n]) begin
                        any = 1;
                        w = (st[k].ptr + i) % n;
                    end
                end
            end
            xfer = any && cs;
            if (xfer) eg[w] = 1'b1;
        end
        chk({nm, "_grants"}, int'(ag), int'(eg));
        chk({nm, "_out_val"}, int'(av), int'(xfer));
        chk({nm, "_locked"}, int'(alk), st[k].lk);
        chk({nm, "_credits"}, acr, st[k].cr);
        if (!reset || st[k].lk != 0 || xfer) chk({nm, "_xbar_sel"}, asel, w);
        if (reset) begin
            if (xfer) begin
                if (tl[w]) begin
                    st[k].lk = 0;
                    st[k].ptr = (w + 1) % n;
                end else begin
                    st[k].lk = 1;
                    st[k].own = w;
                end
            end
            if (ce != 0) begin
                if (xfer && !cret) st[k].cr--;
                else if (!xfer && cret && st[k].cr < pc) st[k].cr++;
            end
        end
    endtask

    logic [4:0] sgA, sgB, sgC;
    logic svA, slA, slB, slC;
    int ssA, scB, scC;

    // Inputs are set at the falling edge; outputs sampled 2 time units later.
    task automatic tick();
        #2;
        model_cmp(0, 3, 0, 4, 8'(rA), 8'(tA), rdyA, 1'b0, 8'(gA), vA, int'(sA), lA, int'(cA), "A");
        model_cmp(1, 3, 1, 2, 8'(rB), 8'(tB), 1'b0, crB, 8'(gB), vB, int'(sB), lB, int'(cB), "B");
        model_cmp(2, 5, 1, 4, 8'(rC), 8'(tC), 1'b0, crC, 8'(gC), vC, int'(sC), lC, int'(cC), "C");
        sgA = 5'(gA); svA = vA; slA = lA; ssA = int'(sA);
        sgB = 5'(gB); slB = lB; scB = int'(cB);
        sgC = 5'(gC); slC = lC; scC = int'(cC);
        @(negedge clk);
    endtask

    task automatic idle_all();
        rA = '0; tA = '0; rdyA = 1'b0;
        rB = '0; tB = '0; crB = 1'b0;
        rC = '0; tC = '0; crC = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_all();
        @(negedge clk);

        // Reset with all inputs requesting
        reset = 1'b0;
        rA = 3'b111; tA = 3'b111; rdyA = 1'b1;
        rB = 3'b111; tB = 3'b111;
        rC = 5'b11111; tC = 5'b11111;
        tick();
        chk("t1_gA", int'(sgA), 0); chk("t1_vA", int'(svA), 0); chk("t1_lA", int'(slA), 0);
        chk("t1_gB", int'(sgB), 0); chk("t1_cB", scB, 2);
        chk("t1_gC", int'(sgC), 0); chk("t1_cC", scC, 4);
        tick();
        reset = 1'b1;
        idle_all();

        // Round-robin over single-flit packets
        do_reset();
        rA = 3'b111; tA = 3'b111; rdyA = 1'b1;
        tick(); chk("t2_g0", int'(sgA), 1);
        tick(); chk("t2_g1", int'(sgA), 2);
        tick(); chk("t2_g2", int'(sgA), 4);
        tick(); chk("t2_g3", int'(sgA), 1);

        // Three-flit packet from in0 holds off in1
        do_reset();
        rA = 3'b011; tA = 3'b000; rdyA = 1'b1;
        tick(); chk("t3_head", int'(sgA), 1);
        tick(); chk("t3_body", int'(sgA), 1); chk("t3_lk1", int'(slA), 1);
        tA = 3'b001;
        tick(); chk("t3_tail", int'(sgA), 1); chk("t3_lk2", int'(slA), 1);
        tA = 3'b010;
        tick(); chk("t3_next", int'(sgA), 2); chk("t3_lk3", int'(slA), 0);

        // Bubble then backpressure while in1 owns the output
        do_reset();
        rA = 3'b010; tA = 3'b000; rdyA = 1'b1;
        tick(); chk("t4_head", int'(sgA), 2);
        rA = 3'b101;
        for (int i = 0; i < 2; i++) begin
            tick(); chk("t4_bub_g", int'(sgA), 0); chk("t4_bub_s", ssA, 1); chk("t4_bub_l", int'(slA), 1);
        end
        rA = 3'b111; rdyA = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); chk("t4_bp_g", int'(sgA), 0); chk("t4_bp_v", int'(svA), 0); chk("t4_bp_s", ssA, 1);
        end
        rdyA = 1'b1; tA = 3'b010;
        tick(); chk("t4_tail", int'(sgA), 2);
        tA = 3'b111;
        tick(); chk("t4_after", int'(sgA), 4);

        // Two credits, stall, single return, simultaneous send and return
        do_reset();
        rB = 3'b111; tB = 3'b111;
        tick(); chk("t5_g0", int'(sgB), 1); chk("t5_c0", scB, 2);
        tick(); chk("t5_g1", int'(sgB), 2); chk("t5_c1", scB, 1);
        tick(); chk("t5_st0", int'(sgB), 0); chk("t5_c2", scB, 0);
        tick(); chk("t5_st1", int'(sgB), 0);
        crB = 1'b1;
        tick(); chk("t5_ret", int'(sgB), 0);
        crB = 1'b0;
        tick(); chk("t5_one", int'(sgB), 4); chk("t5_c3", scB, 1);
        tick(); chk("t5_st2", int'(sgB), 0); chk("t5_c4", scB, 0);
        crB = 1'b1;
        tick();
        tick(); chk("t5_both", int'(sgB), 1); chk("t5_c5", scB, 1);
        crB = 1'b0;
        tick(); chk("t5_held", scB, 1); chk("t5_g2", int'(sgB), 2);

        // N=5 wrap from pointer 4, then reset mid-packet
        do_reset();
        rC = 5'b01000; tC = 5'b11111;
        tick(); chk("t6_g3", int'(sgC), 8);
        crC = 1'b1;
        rC = 5'b10001;
        tick(); chk("t6_g4", int'(sgC), 16);
        tick(); chk("t6_g0", int'(sgC), 1);
        rC = 5'b00100; tC = 5'b00000;
        tick(); chk("t6_head", int'(sgC), 4); chk("t6_c", scC, 3);
        tick(); chk("t6_body", int'(sgC), 4); chk("t6_lk", int'(slC), 1);
        reset = 1'b0; crC = 1'b0;
        tick(); chk("t6_rst_l", int'(slC), 0); chk("t6_rst_g", int'(sgC), 0); chk("t6_rst_c", scC, 4);
        reset = 1'b1;
        rC = 5'b00011; tC = 5'b11111;
        tick(); chk("t6_ptr0", int'(sgC), 1);

        // Randomized traffic with occasional resets
        for (int cyc = 0; cyc < 600; cyc++) begin
            rA = 3'($urandom);
            for (int b = 0; b < 3; b++) tA[b] = ($urandom_range(0, 2) == 0);
            rdyA = ($urandom_range(0, 3) != 0);
            rB = 3'($urandom);
            for (int b = 0; b < 3; b++) tB[b] = ($urandom_range(0, 2) == 0);
            crB = (st[1].cr < 2) && ($urandom_range(0, 1) == 1);
            rC = 5'($urandom);
            for (int b = 0; b < 5; b++) tC[b] = ($urandom_range(0, 2) == 0);
            crC = (st[2].cr < 4) && ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
